// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame-buffer / CPU RAM arbiter.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  localparam logic [15:0] FB_BASE_DEFAULT = 16'hF000;

endpackage

// File: rtl/fb_arb_prio.sv
// Combinational grant decision: a saturated CPU wait beats a pending VGA fetch,
// otherwise VGA beats a fresh CPU request. Zero latency.
module fb_arb_prio (
  input  logic vga_pend_i,
  input  logic cpu_new_i,
  input  logic wait_sat_i,
  output logic owner_cpu_o,
  output logic go_o
);

  always_comb begin
    owner_cpu_o = 1'b0;
    go_o        = 1'b0;
    if (cpu_new_i && wait_sat_i) begin
      owner_cpu_o = 1'b1;
      go_o        = 1'b1;
    end else if (vga_pend_i) begin
      owner_cpu_o = 1'b0;
      go_o        = 1'b1;
    end else if (cpu_new_i) begin
      owner_cpu_o = 1'b1;
      go_o        = 1'b1;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Shares one single-port RAM between the VGA fetcher and the CPU; all outputs registered.
// VGA: strobe edge to vga_valid 3 clk; CPU read 3 clk / write 2 clk when uncontested.
module fb_mem_arbiter
  import fb_arb_pkg::*;
#(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] FB_BASE      = FB_BASE_DEFAULT,
  parameter int                CPU_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              vga_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              fb_dirty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic              fb_hit_q, fb_hit_d;
  logic              vga_pend_q, vga_pend_d;
  logic [ADDR_W-1:0] vga_addr_q, vga_addr_d;
  logic              vga_overrun_q, vga_overrun_d;
  logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              fb_dirty_q, fb_dirty_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic cpu_busy, cpu_new, wait_sat, arb_slot;
  logic owner_cpu, go, grant, grant_vga, grant_cpu;

  // The CPU request being served stays high until its ack, so it must not look new again.
  assign cpu_busy = (state_q != IDLE) && (owner_q == OWN_CPU);
  assign cpu_new  = cpu_req && !cpu_ack_q && !cpu_busy;
  assign wait_sat = (cpu_wait_q == WAIT_W'(CPU_MAX_WAIT));
  assign arb_slot = (state_q == IDLE) || (state_q == READ) ||
                    ((state_q == ISSUE) && we_q);

  fb_arb_prio u_prio (
    .vga_pend_i  (vga_pend_q),
    .cpu_new_i   (cpu_new),
    .wait_sat_i  (wait_sat),
    .owner_cpu_o (owner_cpu),
    .go_o        (go)
  );

  assign grant     = arb_slot && go;
  assign grant_vga = grant && !owner_cpu;
  assign grant_cpu = grant && owner_cpu;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    fb_hit_d      = fb_hit_q;
    vga_pend_d    = vga_pend_q && !grant_vga;
    vga_addr_d    = vga_addr_q;
    vga_overrun_d = vga_overrun_q;
    cpu_wait_d    = cpu_wait_q;
    vga_data_d    = vga_data_q;
    vga_valid_d   = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_ack_d     = 1'b0;
    fb_dirty_d    = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;

    if (vga_req) begin
      vga_pend_d = 1'b1;
      vga_addr_d = vga_addr;
      if (vga_pend_q && !grant_vga) vga_overrun_d = 1'b1;
    end

    if (grant_cpu)                 cpu_wait_d = '0;
    else if (cpu_new && !wait_sat) cpu_wait_d = cpu_wait_q + WAIT_W'(1);

    case (state_q)
      ISSUE: begin
        if (we_q) begin
          cpu_ack_d  = 1'b1;
          fb_dirty_d = fb_hit_q;
          state_d    = IDLE;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = IDLE;
        if (owner_q == OWN_VGA) begin
          vga_data_d  = mem_rdata;
          vga_valid_d = 1'b1;
        end else begin
          cpu_rdata_d = mem_rdata;
          cpu_ack_d   = 1'b1;
        end
      end
      default: ;
    endcase

    // A grant on the last cycle of an access overrides the return to IDLE.
    if (grant) begin
      state_d = ISSUE;
      owner_d = owner_cpu ? OWN_CPU : OWN_VGA;
      if (grant_vga) begin
        mem_addr_d = vga_addr_q;
        we_d       = 1'b0;
        fb_hit_d   = 1'b0;
      end else begin
        mem_addr_d = cpu_addr;
        we_d       = cpu_we;
        mem_we_d   = cpu_we;
        fb_hit_d   = cpu_we && (cpu_addr >= FB_BASE);
        if (cpu_we) mem_wdata_d = cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_VGA;
      we_q          <= 1'b0;
      fb_hit_q      <= 1'b0;
      vga_pend_q    <= 1'b0;
      vga_addr_q    <= '0;
      vga_overrun_q <= 1'b0;
      cpu_wait_q    <= '0;
      vga_data_q    <= '0;
      vga_valid_q   <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      fb_dirty_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      fb_hit_q      <= fb_hit_d;
      vga_pend_q    <= vga_pend_d;
      vga_addr_q    <= vga_addr_d;
      vga_overrun_q <= vga_overrun_d;
      cpu_wait_q    <= cpu_wait_d;
      vga_data_q    <= vga_data_d;
      vga_valid_q   <= vga_valid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      fb_dirty_q    <= fb_dirty_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign vga_data    = vga_data_q;
  assign vga_valid   = vga_valid_q;
  assign vga_overrun = vga_overrun_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign fb_dirty    = fb_dirty_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a synchronous-read RAM model.
// Inputs change 1 time unit after a rising edge; "edge +N" below counts edges from that drive point.
module tb_fb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic [15:0] vga_data;
  logic        vga_valid;
  logic        vga_overrun;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        fb_dirty;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        pl_we;
  logic [15:0] pl_addr;
  logic [15:0] pl_dat;
  logic [15:0] ram [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .vga_req     (vga_req),
    .vga_addr    (vga_addr),
    .vga_data    (vga_data),
    .vga_valid   (vga_valid),
    .vga_overrun (vga_overrun),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .fb_dirty    (fb_dirty),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // RAM: address sampled at an edge, data valid for the following cycle.
  always @(posedge clk) begin
    if (pl_we)       ram[pl_addr]  <= pl_dat;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if ({vga_valid, vga_overrun, cpu_ack, fb_dirty, mem_we} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {vga_valid, vga_overrun, cpu_ack, fb_dirty, mem_we}); end
    checks++; if ({vga_data, cpu_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      failures++; $display("FAIL reset_words got=%h exp=0", {vga_data, cpu_rdata, mem_addr, mem_wdata}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_vga_fetch();
    vga_req = 1'b1; vga_addr = 16'hF005;
    tick();                       // E0: strobe sampled
    vga_req = 1'b0; vga_addr = 16'h0000;
    tick();                       // E1: fetch issued
    checks++; if (mem_addr !== 16'hF005 || mem_we !== 1'b0) begin
      failures++; $display("FAIL vga_issue addr=%h we=%b exp addr=f005 we=0", mem_addr, mem_we); end
    checks++; if (vga_valid !== 1'b0) begin
      failures++; $display("FAIL vga_e1_valid got=%b exp=0", vga_valid); end
    tick();                       // E2
    checks++; if (vga_valid !== 1'b0) begin
      failures++; $display("FAIL vga_e2_valid got=%b exp=0", vga_valid); end
    tick();                       // E3
    checks++; if (vga_valid !== 1'b1 || vga_data !== 16'h4142) begin
      failures++; $display("FAIL vga_e3 valid=%b data=%h exp valid=1 data=4142", vga_valid, vga_data); end
    tick();                       // E4: single pulse, data held
    checks++; if (vga_valid !== 1'b0 || vga_data !== 16'h4142) begin
      failures++; $display("FAIL vga_e4 valid=%b data=%h exp valid=0 data=4142", vga_valid, vga_data); end
    repeat (2) tick();
  endtask

  task automatic test_cpu_write_fb();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hF010; cpu_wdata = 16'hBEEF;
    tick();                       // +1: ISSUE with write strobe
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'hF010 || mem_wdata !== 16'hBEEF || cpu_ack !== 1'b0) begin
      failures++; $display("FAIL wr_issue we=%b addr=%h wd=%h ack=%b exp 1 f010 beef 0", mem_we, mem_addr, mem_wdata, cpu_ack); end
    tick();                       // +2: ack
    checks++; if (mem_we !== 1'b0 || cpu_ack !== 1'b1 || fb_dirty !== 1'b1) begin
      failures++; $display("FAIL wr_ack we=%b ack=%b dirty=%b exp 0 1 1", mem_we, cpu_ack, fb_dirty); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    checks++; if (ram[16'hF010] !== 16'hBEEF || cpu_ack !== 1'b0 || fb_dirty !== 1'b0) begin
      failures++; $display("FAIL wr_after ram=%h ack=%b dirty=%b exp beef 0 0", ram[16'hF010], cpu_ack, fb_dirty); end
    // Read back; the request stays high through the ack cycle and must not be served twice.
    cpu_req = 1'b1; cpu_addr = 16'hF010;
    tick(); tick();
    checks++; if (cpu_ack !== 1'b0) begin
      failures++; $display("FAIL rd_early_ack got=%b exp=0", cpu_ack); end
    tick();
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hBEEF || fb_dirty !== 1'b0) begin
      failures++; $display("FAIL rd_ack ack=%b data=%h dirty=%b exp 1 beef 0", cpu_ack, cpu_rdata, fb_dirty); end
    tick();
    cpu_req = 1'b0;
    tick(); tick();
    checks++; if (cpu_ack !== 1'b0) begin
      failures++; $display("FAIL rd_double_ack got=%b exp=0", cpu_ack); end
    repeat (2) tick();
  endtask

  task automatic test_cpu_write_low();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h1234;
    tick(); tick();
    checks++; if (cpu_ack !== 1'b1 || fb_dirty !== 1'b0) begin
      failures++; $display("FAIL low_wr ack=%b dirty=%b exp 1 0", cpu_ack, fb_dirty); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    checks++; if (ram[16'h0100] !== 16'h1234) begin
      failures++; $display("FAIL low_wr_ram got=%h exp=1234", ram[16'h0100]); end
    repeat (2) tick();
  endtask

  task automatic test_contention();
    int start = 0;
    int acks = 0;
    int vvalids = 0;
    cpu_we = 1'b0; cpu_addr = 16'h0200; vga_addr = 16'hF005;
    for (int c = 0; c < 64; c++) begin
      vga_req = (c < 48) && (c % 4 == 0);
      if (!cpu_req && c < 48) begin cpu_req = 1'b1; start = c; end
      tick();
      if (vga_valid) begin
        vvalids++;
        checks++; if (vga_data !== 16'h4142) begin
          failures++; $display("FAIL cont_vga_data got=%h exp=4142", vga_data); end
      end
      if (cpu_ack) begin
        acks++;
        checks++; if (c + 1 - start > 11 || cpu_rdata !== 16'h5A5A) begin
          failures++; $display("FAIL cont_cpu wait=%0d data=%h exp wait<=11 data=5a5a", c + 1 - start, cpu_rdata); end
        cpu_req = 1'b0;
      end else if (cpu_req && c + 1 - start > 11) begin
        failures++; checks++;
        $display("FAIL cont_cpu_timeout wait=%0d exp<=11", c + 1 - start);
        cpu_req = 1'b0;
      end
    end
    vga_req = 1'b0;
    checks++; if (vga_overrun !== 1'b0 || vvalids != 12 || acks < 6) begin
      failures++; $display("FAIL cont_summary overrun=%b valids=%0d acks=%0d exp 0 12 >=6", vga_overrun, vvalids, acks); end
  endtask

  task automatic test_overrun();
    int vv = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
    vga_req = 1'b1; vga_addr = 16'hF020;
    tick();                       // +1: CPU granted, first fetch pending
    vga_addr = 16'hF021;
    tick();                       // +2: second strobe while pending
    vga_req = 1'b0;
    checks++; if (vga_overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_flag got=%b exp=1", vga_overrun); end
    tick();                       // +3: CPU read done, VGA granted
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1111 || mem_addr !== 16'hF021) begin
      failures++; $display("FAIL ovr_cpu ack=%b data=%h addr=%h exp 1 1111 f021", cpu_ack, cpu_rdata, mem_addr); end
    cpu_req = 1'b0;
    tick(); tick();               // +5
    checks++; if (vga_valid !== 1'b1 || vga_data !== 16'hBBBB) begin
      failures++; $display("FAIL ovr_fetch valid=%b data=%h exp 1 bbbb", vga_valid, vga_data); end
    for (int k = 0; k < 6; k++) begin tick(); if (vga_valid) vv++; end
    checks++; if (vv != 0 || vga_overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_extra valids=%0d overrun=%b exp 0 1", vv, vga_overrun); end
  endtask

  task automatic test_starvation();
    int first = -1;
    // VGA strobes every cycle keep a fetch pending at every arbitration point.
    vga_req = 1'b1; vga_addr = 16'hF005;
    tick(); tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0500;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (cpu_ack && first < 0) begin
        first = k;
        checks++; if (cpu_rdata !== 16'h5555) begin
          failures++; $display("FAIL starve_data got=%h exp=5555", cpu_rdata); end
        cpu_req = 1'b0;
      end
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    checks++; if (first != 12) begin
      failures++; $display("FAIL starve_latency got=%0d exp=12", first); end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_read();
    int seen = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    tick(); tick();               // +2: in READ
    reset = 1'b1;
    tick();                       // +3: reset sampled
    checks++; if (cpu_ack !== 1'b0 || vga_overrun !== 1'b0 || mem_addr !== 16'h0000) begin
      failures++; $display("FAIL rst_mid ack=%b overrun=%b addr=%h exp 0 0 0000", cpu_ack, vga_overrun, mem_addr); end
    reset = 1'b0;
    tick(); tick();               // release +2
    if (cpu_ack) seen++;
    checks++; if (seen != 0) begin
      failures++; $display("FAIL rst_early_ack got=%0d exp=0", seen); end
    tick();                       // release +3
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h7777) begin
      failures++; $display("FAIL rst_reack ack=%b data=%h exp 1 7777", cpu_ack, cpu_rdata); end
    cpu_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    reset = 1'b1; vga_req = 1'b0; vga_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
    preload(16'hF005, 16'h4142);
    preload(16'h0200, 16'h5A5A);
    preload(16'h0300, 16'h1111);
    preload(16'hF020, 16'hAAAA);
    preload(16'hF021, 16'hBBBB);
    preload(16'h0400, 16'h7777);
    preload(16'h0500, 16'h5555);
    test_reset();
    test_vga_fetch();
    test_cpu_write_fb();
    test_cpu_write_low();
    test_contention();
    test_overrun();
    test_starvation();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
